fifo_sync_flags: RTL and testbench

//  Single-clock FIFO built on an internal dual-port memory array, with word count,

---
 rtl/fifo_sync_flags_if.sv | 29 ++
 rtl/fifo_sync_flags.sv | 78 +++++++
 tb/tb_fifo_sync_flags.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: write/read handshake and status bundle of the synchronous FIFO
interface fifo_sync_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             i_Wr_DV;
  logic [WIDTH-1:0] i_Wr_Data;
  logic             o_Full;
  logic             o_AF_Flag;
  logic             i_Rd_En;
  logic             o_Rd_DV;
  logic [WIDTH-1:0] o_Rd_Data;
  logic             o_Empty;
  logic             o_AE_Flag;
  logic [CW-1:0]    o_Count;
  logic             o_Overflow;
  logic             o_Underflow;
  modport master (
    output i_Wr_DV, i_Wr_Data, i_Rd_En,
    input  o_Full, o_AF_Flag, o_Rd_DV, o_Rd_Data, o_Empty, o_AE_Flag,
           o_Count, o_Overflow, o_Underflow
  );
  modport slave (
    input  i_Wr_DV, i_Wr_Data, i_Rd_En,
    output o_Full, o_AF_Flag, o_Rd_DV, o_Rd_Data, o_Empty, o_AE_Flag,
           o_Count, o_Overflow, o_Underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with count, full/empty, almost flags and sticky over/underflow
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  fifo_sync_flags_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic             rd_dv_q, rd_dv_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_acc, rd_acc;
  // Acceptance uses the registered flags, so a full/empty FIFO never falls through
  always_comb begin
    wr_acc    = bus.i_Wr_DV & ~full_q;
    rd_acc    = bus.i_Rd_En & ~empty_q;
    wr_ptr_d  = wr_acc ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d  = rd_acc ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d    = count_d == CW'(DEPTH);
    empty_d   = count_d == '0;
    af_d      = count_d >= CW'(AF_LEVEL);
    ae_d      = count_d <= CW'(AE_LEVEL);
    rd_dv_d   = rd_acc;
    rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    ovf_d     = ovf_q | (bus.i_Wr_DV & full_q);
    unf_d     = unf_q | (bus.i_Rd_En & empty_q);
  end
  // Storage array is deliberately left out of reset
  always_ff @(posedge i_Clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.i_Wr_Data;
  end
  // Pointers, count, flags and read port state
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      rd_dv_q   <= 1'b0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      rd_dv_q   <= rd_dv_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
  assign bus.o_Full      = full_q;
  assign bus.o_AF_Flag   = af_q;
  assign bus.o_Empty     = empty_q;
  assign bus.o_AE_Flag   = ae_q;
  assign bus.o_Count     = count_q;
  assign bus.o_Rd_DV     = rd_dv_q;
  assign bus.o_Rd_Data   = rd_data_q;
  assign bus.o_Overflow  = ovf_q;
  assign bus.o_Underflow = unf_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed and random checks of fifo_sync_flags against a queue model
module tb_fifo_sync_flags;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] q [$];
  logic       m_dv = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  fifo_sync_flags_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();
  fifo_sync_flags #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(bus.o_Count), 32'(q.size()));
    chk({tag, ".full"}, 32'(bus.o_Full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.o_Empty), 32'(q.size() == 0));
    chk({tag, ".af"}, 32'(bus.o_AF_Flag), 32'(q.size() >= 14));
    chk({tag, ".ae"}, 32'(bus.o_AE_Flag), 32'(q.size() <= 2));
    chk({tag, ".rd_dv"}, 32'(bus.o_Rd_DV), 32'(m_dv));
    chk({tag, ".rd_data"}, 32'(bus.o_Rd_Data), 32'(m_data));
    chk({tag, ".ovf"}, 32'(bus.o_Overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.o_Underflow), 32'(m_unf));
  endtask
  task automatic model_reset();
    q.delete();
    m_dv = 1'b0;
    m_data = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  task automatic step(input string tag, input logic wr, input logic [7:0] d, input logic rd);
    bit full, empty;
    bus.i_Wr_DV = wr;
    bus.i_Wr_Data = d;
    bus.i_Rd_En = rd;
    @(posedge clk);
    full = q.size() == DEPTH;
    empty = q.size() == 0;
    m_ovf |= wr && full;
    m_unf |= rd && empty;
    m_dv = rd && !empty;
    if (rd && !empty) m_data = q.pop_front();
    if (wr && !full) q.push_back(d);
    #1;
    chk_all(tag);
  endtask
  initial begin
    bus.i_Wr_DV = 1'b0;
    bus.i_Wr_Data = 8'h00;
    bus.i_Rd_En = 1'b0;
    #12;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 16; i++) step("refill", 1'b1, 8'(i + 8'h30), 1'b0);
    step("ovf_write", 1'b1, 8'hAA, 1'b0);
    step("full_wr_rd", 1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 15; i++) step("drain2", 1'b0, 8'h00, 1'b1);
    step("unf_read", 1'b0, 8'h00, 1'b1);
    step("idle", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 20; i++) step("wr_rd", 1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) step("drain5", 1'b0, 8'h00, 1'b1);
    step("empty_wr_rd", 1'b1, 8'h55, 1'b1);
    step("read55", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
    while (q.size() > 0) step("flush", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step("fill8", 1'b1, 8'(8'hC0 + i), 1'b0);
    step("mid_read", 1'b0, 8'h00, 1'b1);
    bus.i_Rd_En = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst");
    bus.i_Rd_En = 1'b0;
    @(negedge clk);
    chk_all("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_wr", 1'b1, 8'(8'hE0 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("post_rst_rd", 1'b0, 8'h00, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
